race_encoder4: RTL and testbench
================================

Name: race_encoder4

Overview:
- Temporal (race-logic) transmitter for the 4-lane sorting network.
- Accepts four binary values over a valid/ready handshake.
- Emits each value as a step-coded edge on its own output lane: value v rises v cycles after acceptance and stays high to the end of the window.
- Feeds the 4-input race-logic sorter directly. Sorter min/max semantics (first/last arrival) need monotonic, glitch-free registered edges.

Parameters:
- WIDTH, 3, bits per lane value; window length is 2^WIDTH cycles.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  source has a 4-value vector
- in_ready  out  1  encoder idle and able to accept
- in_data  in  4*WIDTH  lane i value = in_data[i*WIDTH +: WIDTH]
- out  out  4  step-coded lane edges, registered, to sorter inputs
- busy  out  1  encoding window in progress
- done  out  1  one-cycle pulse, window complete

Behaviour:
- Reset (async, rst_n=0): state=IDLE, t=0, latched values=0, out=4'b0000, busy=0, done=0, in_ready=1. Reset mid-window aborts immediately, with no done pulse.
- States: IDLE, RUN, DONE.
- Moore outputs: in_ready=(state==IDLE); busy=(state==RUN); done=(state==DONE).
- IDLE: out=0. Handshake occurs at rising edge E0 when in_valid & in_ready.
  - At E0: latch the four values; t<=0; state<=RUN; out[i]<=(in_data lane i == 0).
  - in_data is ignored whenever in_ready=0.
- RUN, at edge Ek (k>=1):
  - t<=k.
  - out[i]<=out[i] | (val[i]==k).
  - After edge Ek, out[i]=1 iff val[i]<=k.
  - Lanes are monotonic: never fall inside a window.
  - Equal values rise on the same edge.
- RUN exit: at the edge after t reaches 2^WIDTH-1, state<=DONE; out held (all ones).
- DONE: lasts one cycle. Next edge: state<=IDLE, out<=0, t<=0.
- Timeline (no feature): accept E0, lane v high after E_v, done high after E_{2^WIDTH}, in_ready high after E_{2^WIDTH+1}.
- Back-to-back: a new vector can be accepted at the first edge where in_ready=1. Minimum spacing is 2^WIDTH+2 cycles.
- t width is WIDTH bits. It never wraps inside a window; the exit check happens at t==2^WIDTH-1.
- Value 2^WIDTH-1 is a legal latest arrival. There is no "never fires" encoding.

Optional Feature:
- Macro: RACE_ENCODER_EARLY_DONE_EN.
- Defined: also latch vmax = max of the four values at E0. RUN exits at the edge after t==vmax, giving done after E_{vmax+1} and in_ready after E_{vmax+2}. All ones at exit still holds.
- vmax==0 case: RUN lasts one cycle; done after E1.
- Undefined: fixed 2^WIDTH-cycle window as above; the vmax register is absent.

Test Plan (WIDTH=3):
- Reset: hold rst_n=0 with in_valid=1 -> out=0000, in_ready=1, busy=0, done=0. Deassert -> accept on the next edge.
- Values {lane0..3}={0,7,3,3}:
  - out=0001 after E0, 1101 after E3, 1111 after E7.
  - done=1 only after E8; out=0000 and in_ready=1 after E9.
  - Check no lane ever falls during the window.
- Values {1,2,0,2}:
  - Without macro: out=0100, 0101, 1111 after E0..E2; done after E8.
  - With RACE_ENCODER_EARLY_DONE_EN: done after E3, in_ready after E4.
- Busy ignore: hold in_valid=1 with changing in_data during RUN -> latched values unchanged. The second vector is accepted exactly at the first edge with in_ready=1.
- Async reset at E4 of a {0,7,3,3} window -> out=0000 immediately, no done pulse, IDLE.
- End-to-end: encoder out drives the sorter with {5,1,6,2}. Sorted outputs rise after E1, E2, E5, E6 in lane order min..max.

Source files
------------

// File: rtl/race_encoder4.sv
// Race-logic transmitter: turns four WIDTH-bit values into step-coded, monotonic lane edges.
// Optional feature macro RACE_ENCODER_EARLY_DONE_EN ends the window right after the latest lane fires.
module race_encoder4 #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           stateReg, stateNext;
  logic [WIDTH-1:0] tReg, tNext, tPlus, lastT;
  logic [WIDTH-1:0] valReg  [4];
  logic [WIDTH-1:0] valNext [4];
  logic [WIDTH-1:0] laneVal [4];
  logic [3:0]       outReg, outNext, laneZero, laneHit;

  assign tPlus = tReg + 1'b1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign laneVal[gi]  = in_data[gi*WIDTH +: WIDTH];
      assign laneZero[gi] = (laneVal[gi] == '0);
      // Lane fires on the edge where t becomes its value.
      assign laneHit[gi]  = (valReg[gi] == tPlus);
    end
  endgenerate

`ifdef RACE_ENCODER_EARLY_DONE_EN
  logic [WIDTH-1:0] vmaxReg, vmaxNext, vmaxIn;

  always_comb begin
    vmaxIn = laneVal[0];
    for (int i = 1; i < 4; i++) begin
      if (laneVal[i] > vmaxIn) vmaxIn = laneVal[i];
    end
  end

  assign lastT = vmaxReg;
`else
  assign lastT = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      tReg     <= '0;
      outReg   <= '0;
      for (int i = 0; i < 4; i++) valReg[i] <= '0;
`ifdef RACE_ENCODER_EARLY_DONE_EN
      vmaxReg  <= '0;
`endif
    end else begin
      stateReg <= stateNext;
      tReg     <= tNext;
      outReg   <= outNext;
      for (int i = 0; i < 4; i++) valReg[i] <= valNext[i];
`ifdef RACE_ENCODER_EARLY_DONE_EN
      vmaxReg  <= vmaxNext;
`endif
    end
  end

  always_comb begin
    stateNext = stateReg;
    tNext     = tReg;
    outNext   = outReg;
    for (int i = 0; i < 4; i++) valNext[i] = valReg[i];
`ifdef RACE_ENCODER_EARLY_DONE_EN
    vmaxNext  = vmaxReg;
`endif
    case (stateReg)
      IDLE: begin
        outNext = '0;
        tNext   = '0;
        if (in_valid) begin
          stateNext = RUN;
          outNext   = laneZero;
          for (int i = 0; i < 4; i++) valNext[i] = laneVal[i];
`ifdef RACE_ENCODER_EARLY_DONE_EN
          vmaxNext  = vmaxIn;
`endif
        end
      end
      RUN: begin
        // Exit check sits before the increment so t never wraps within a window.
        if (tReg == lastT) begin
          stateNext = DONE;
        end else begin
          tNext   = tPlus;
          outNext = outReg | laneHit;
        end
      end
      DONE: begin
        stateNext = IDLE;
        outNext   = '0;
        tNext     = '0;
      end
      default: begin
        stateNext = IDLE;
        outNext   = '0;
        tNext     = '0;
      end
    endcase
  end

  assign out      = outReg;
  assign in_ready = (stateReg == IDLE);
  assign busy     = (stateReg == RUN);
  assign done     = (stateReg == DONE);

endmodule

// File: tb/tb_race_encoder4.sv
// Scoreboard bench for race_encoder4: expected per-cycle traces are queued at acceptance.
// Honours RACE_ENCODER_EARLY_DONE_EN when compiled with the same define as the RTL.
module tb_race_encoder4;

  localparam int W = 3;
`ifdef RACE_ENCODER_EARLY_DONE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [4*W-1:0] inData = '0;
  logic [3:0]   laneOut;
  logic         busy;
  logic         done;

  int passCount = 0;
  int checkCount = 0;
  logic [6:0] sbQ[$];

  race_encoder4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
    .in_data(inData), .out(laneOut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [4*W-1:0] pack(input int v0, input int v1, input int v2, input int v3);
    logic [W-1:0] a, b, c, d;
    a = W'(v0); b = W'(v1); c = W'(v2); d = W'(v3);
    return {d, c, b, a};
  endfunction

  // Expected {out, in_ready, busy, done} after E0, E1, ... until back in IDLE.
  task automatic pushTrace(input logic [4*W-1:0] data);
    int vals[4];
    int exitT;
    logic [3:0] o;
    exitT = 0;
    for (int i = 0; i < 4; i++) begin
      vals[i] = int'(data[i*W +: W]);
      if (vals[i] > exitT) exitT = vals[i];
    end
    if (!EARLY) exitT = (1 << W) - 1;
    for (int k = 0; k <= exitT; k++) begin
      for (int i = 0; i < 4; i++) o[i] = (vals[i] <= k);
      sbQ.push_back({o, 1'b0, 1'b1, 1'b0});
    end
    sbQ.push_back({4'hF, 1'b0, 1'b0, 1'b1});
    sbQ.push_back({4'h0, 1'b1, 1'b0, 1'b0});
  endtask

  task automatic waitReady(input string name);
    int n;
    n = 0;
    while (!inReady && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) begin
      checkCount++;
      $display("FAIL %s ready_timeout: in_ready=%b required 1 within 40 cycles", name, inReady);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    inValid = 1'b1;
    inData = pack(0, 7, 3, 3);
    repeat (3) @(negedge clk);
    checkCount++;
    if ({laneOut, inReady, busy, done} !== 7'b0000_100)
      $display("FAIL reset_state: got %b required %b", {laneOut, inReady, busy, done}, 7'b0000_100);
    else passCount++;
    rstN = 1'b1;
    @(negedge clk);
    checkCount++;
    if ({laneOut, inReady, busy, done} !== 7'b0001_010)
      $display("FAIL reset_first_accept: got %b required %b", {laneOut, inReady, busy, done}, 7'b0001_010);
    else passCount++;
    inValid = 1'b0;
    waitReady("reset");
    $display("test_reset: idle state and first accept after release checked");
  endtask

  task automatic test_window(input string name, input int v0, input int v1, input int v2, input int v3);
    logic [6:0] exp, obs;
    logic [3:0] prev;
    int cyc;
    waitReady(name);
    inData = pack(v0, v1, v2, v3);
    inValid = 1'b1;
    pushTrace(inData);
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    prev = '0;
    cyc = 0;
    while (sbQ.size() > 0) begin
      exp = sbQ.pop_front();
      obs = {laneOut, inReady, busy, done};
      checkCount++;
      if (obs !== exp)
        $display("FAIL %s trace E%0d: got %b required %b", name, cyc, obs, exp);
      else passCount++;
      if (exp[1] || exp[0]) begin
        checkCount++;
        if ((prev & ~laneOut) !== 4'b0)
          $display("FAIL %s monotonic E%0d: out=%b previous %b", name, cyc, laneOut, prev);
        else passCount++;
      end
      prev = laneOut;
      cyc++;
      if (sbQ.size() > 0) @(negedge clk);
    end
    $display("test_window %s: {%0d,%0d,%0d,%0d} window of %0d cycles checked", name, v0, v1, v2, v3, cyc);
  endtask

  task automatic test_busy_ignore();
    logic [6:0] exp, obs;
    logic [4*W-1:0] dataB;
    bit sentB;
    int cyc;
    waitReady("busy_ignore");
    dataB = pack(6, 1, 3, 7);
    inData = pack(2, 5, 0, 4);
    inValid = 1'b1;
    pushTrace(inData);
    @(posedge clk);
    @(negedge clk);
    sentB = 1'b0;
    cyc = 0;
    while (sbQ.size() > 0) begin
      exp = sbQ.pop_front();
      obs = {laneOut, inReady, busy, done};
      checkCount++;
      if (obs !== exp)
        $display("FAIL busy_ignore trace step%0d: got %b required %b", cyc, obs, exp);
      else passCount++;
      if (sentB) begin
        inValid = 1'b0;
      end else if (sbQ.size() == 0) begin
        inData = dataB;
        pushTrace(dataB);
        sentB = 1'b1;
      end else begin
        inData = (4*W)'($urandom);
      end
      cyc++;
      if (sbQ.size() > 0) @(negedge clk);
    end
    inValid = 1'b0;
    $display("test_busy_ignore: A held against changing data, B accepted at first ready edge (%0d steps)", cyc);
  endtask

  task automatic test_async_reset();
    bit doneSeen;
    waitReady("async_reset");
    inData = pack(0, 7, 3, 3);
    inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkCount++;
    if ({laneOut, inReady, busy, done} !== 7'b0000_100)
      $display("FAIL async_reset_immediate: got %b required %b", {laneOut, inReady, busy, done}, 7'b0000_100);
    else passCount++;
    doneSeen = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) doneSeen = 1'b1;
    end
    checkCount++;
    if (doneSeen !== 1'b0)
      $display("FAIL async_reset_no_done: done seen=%b required 0", doneSeen);
    else passCount++;
    checkCount++;
    if ({laneOut, inReady, busy, done} !== 7'b0000_100)
      $display("FAIL async_reset_idle: got %b required %b", {laneOut, inReady, busy, done}, 7'b0000_100);
    else passCount++;
    $display("test_async_reset: abort at E4 checked");
  endtask

  task automatic test_end_to_end();
    int sortedVals[4] = '{1, 2, 5, 6};
    logic [3:0] exp, obs;
    waitReady("end_to_end");
    inData = pack(5, 1, 6, 2);
    inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      // Race-logic sorter: output j rises once more than j lanes have arrived.
      for (int j = 0; j < 4; j++) begin
        obs[j] = ($countones(laneOut) > j);
        exp[j] = (k >= sortedVals[j]);
      end
      checkCount++;
      if (obs !== exp)
        $display("FAIL end_to_end sorted E%0d: got %b required %b", k, obs, exp);
      else passCount++;
      @(negedge clk);
    end
    waitReady("end_to_end");
    $display("test_end_to_end: {5,1,6,2} through sorter model checked");
  endtask

  initial begin
    test_reset();
    test_window("v0733", 0, 7, 3, 3);
    test_window("v1202", 1, 2, 0, 2);
    test_window("v0000", 0, 0, 0, 0);
    test_window("v7777", 7, 7, 7, 7);
    test_busy_ignore();
    test_async_reset();
    test_window("v4615", 4, 6, 1, 5);
    test_end_to_end();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
